pipe_flush_ctrl: RTL and testbench
==================================

// Module: pipe_flush_ctrl
// PURPOSE
//  Central stall/flush controller for the NUM_STAGES-deep MIPS pipeline.
//  - Arbitrates exception, ERET, MDU-busy, load-use and branch-redirect events into per-register enable/clear vectors and PC control.
//  - After an exception or ERET, a small FSM holds a programmable post-flush window so CP0 state settles before refetch.
//  - Successor to the all-or-nothing exception clear: it kills only the faulting and younger instructions, and lets older instructions drain.
// PARAMETERS
//  NUM_STAGES    5   pipeline stages (IF,ID,EX,MEM,WB); NREG=NUM_STAGES-1 pipeline registers, reg j sits between stage j and j+1
//  FLUSH_CYCLES  2   post-flush bubble cycles after exception/ERET (0 = no FLUSH state)
//  COMMIT_STAGE  3   stage index where ERET commits
//  CNT_W         32  perf counter width (PIPE_CTRL_PERF_EN only)
// PORTS
//  clk           in   1                  clock, rising edge
//  reset         in   1                  asynchronous, active-high
//  exc_req       in   1                  exception/interrupt detected this cycle
//  exc_stage     in   $clog2(NUM_STAGES) stage holding the faulting instruction
//  eret_req      in   1                  ERET committing in COMMIT_STAGE
//  mdu_busy      in   1                  EX op waits on busy mult/div unit
//  ld_use_stall  in   1                  load-use hazard detected in ID
//  br_flush      in   1                  branch/jump redirect resolved in ID
//  pc_en         out  1                  PC write enable
//  pc_sel        out  2                  00 sequential/branch, 01 exception vector, 10 EPC
//  epc_we        out  1                  one-cycle EPC/Cause capture strobe
//  reg_en        out  NREG               pipeline register write enable; 1 = advance
//  reg_clr       out  NREG               sync clear to bubble; overrides reg_en
//  busy          out  1                  FSM not in IDLE
// BEHAVIOUR
//  - Outputs are combinational from state + inputs (Mealy). The only registers are the FSM and the down-counter.
//  - Reset value: state=IDLE, cnt=0.
//    - While reset is high: pc_en=0, reg_en=0, reg_clr=all 1, pc_sel=00, epc_we=0, busy=0.
//  - Default (no event): pc_en=1, reg_en=all 1, reg_clr=0, pc_sel=00.
//  - Event priority per cycle: exc_req > eret_req > mdu_busy > ld_use_stall > br_flush. Lower-priority events in the same cycle are ignored.
//  - exc_req (accepted in IDLE or FLUSH):
//    - Same cycle: reg_clr[0..k]=1 with k=min(exc_stage,NREG-1); regs above k advance; pc_sel=01, pc_en=1, epc_we=1.
//    - Next state: FLUSH with cnt=FLUSH_CYCLES (stays IDLE if FLUSH_CYCLES=0).
//  - eret_req (IDLE only): same as exc_req with k=COMMIT_STAGE, except pc_sel=10 and epc_we=0.
//  - FLUSH: pc_en=0, reg_clr[0]=1, all other regs advance (older instructions drain). cnt decrements; at cnt==1 return to IDLE.
//    - exc_req in FLUSH restarts the sequence.
//    - eret_req, stalls and br_flush are ignored in FLUSH.
//  - mdu_busy (IDLE): pc_en=0, reg_en[0]=reg_en[1]=0, reg_clr[2]=1 (bubble into EX/MEM). Held for as long as mdu_busy is high.
//  - ld_use_stall (IDLE): pc_en=0, reg_en[0]=0, reg_clr[1]=1 (bubble into ID/EX). Exactly one cycle per assertion.
//  - br_flush (IDLE, no stall): pc_en=1, reg_clr[0]=1 (kill the delay-less wrong-path fetch).
//    - If a stall coincides, br_flush is dropped; ID re-resolves it next cycle.
//  - Reset asserted mid-FLUSH: immediate return to IDLE with cnt=0; no epc_we is issued.
// CONFIGURATION
//  - PIPE_CTRL_PERF_EN defined: adds outputs stall_cnt and flush_cnt (CNT_W each, reset 0, saturating at all-ones).
//    - stall_cnt increments every cycle pc_en=0.
//    - flush_cnt increments on each accepted exc_req/eret_req.
//  - PIPE_CTRL_PERF_EN undefined: both ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package pipe_ctrl_pkg: PCSEL_SEQ/PCSEL_EXC/PCSEL_EPC encodings, FSM state encoding (ST_IDLE, ST_FLUSH), stage index constants (STG_IF..STG_WB).
//  - Sub-module sat_cnt (CNT_W saturating increment counter, clk/reset/inc/q), instantiated twice under PIPE_CTRL_PERF_EN.
// TESTING
//  - Exception at exc_stage=2 in IDLE:
//    - Same cycle: reg_clr=4'b0111, reg_en[3]=1, pc_sel=01, epc_we=1.
//    - Next 2 cycles: pc_en=0, reg_clr=4'b0001, busy=1.
//    - Third cycle: IDLE.
//  - ld_use_stall and br_flush together: pc_en=0, reg_en=4'b1110, reg_clr=4'b0010. br_flush has no effect.
//  - mdu_busy held 4 cycles: pc_en=0 for 4 cycles, reg_clr[2]=1 each cycle; with PERF_EN, stall_cnt=4.
//  - exc_req at exc_stage=1 during FLUSH cycle 1: reg_clr=4'b0011, epc_we=1, cnt reloads to 2, busy stays high.
//  - exc_req and eret_req in the same cycle: exception wins (pc_sel=01, epc_we=1); ERET dropped.
//  - Reset asserted mid-FLUSH: reg_clr=4'b1111, pc_en=0, busy=0; after release, default outputs with no spurious epc_we.

Source files
------------

// File: rtl/pipe_flush_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// pipe_ctrl_pkg : shared encodings for the pipeline stall/flush controller
// Revision 1.0
// =============================================================================
package pipe_ctrl_pkg;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_EXC = 2'b01;
  localparam logic [1:0] PCSEL_EPC = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_flush_ctrl_if.sv
`default_nettype none
// =============================================================================
// pipe_flush_ctrl_if : hazard-event inputs and pipeline control outputs
// Revision 1.0
// =============================================================================
interface pipe_flush_ctrl_if #(
  parameter int NUM_STAGES = 5
);
  localparam int NREG = NUM_STAGES - 1;
  localparam int SW   = $clog2(NUM_STAGES);

  logic            i_exc_req;
  logic [SW-1:0]   i_exc_stage;
  logic            i_eret_req;
  logic            i_mdu_busy;
  logic            i_ld_use_stall;
  logic            i_br_flush;
  logic            o_pc_en;
  logic [1:0]      o_pc_sel;
  logic            o_epc_we;
  logic [NREG-1:0] o_reg_en;
  logic [NREG-1:0] o_reg_clr;
  logic            o_busy;

  // Pipeline/hazard side: raises events, consumes control
  modport master (
    output i_exc_req, i_exc_stage, i_eret_req, i_mdu_busy, i_ld_use_stall, i_br_flush,
    input  o_pc_en, o_pc_sel, o_epc_we, o_reg_en, o_reg_clr, o_busy
  );

  modport slave (
    input  i_exc_req, i_exc_stage, i_eret_req, i_mdu_busy, i_ld_use_stall, i_br_flush,
    output o_pc_en, o_pc_sel, o_epc_we, o_reg_en, o_reg_clr, o_busy
  );

endinterface : pipe_flush_ctrl_if
`default_nettype wire

// File: rtl/pipe_flush_ctrl_sat_cnt.sv
`default_nettype none
// =============================================================================
// sat_cnt : W-bit incrementing counter that sticks at all-ones
// Revision 1.0
// =============================================================================
module sat_cnt #(
  parameter int W = 32
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         i_inc,
  output logic      [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign o_q = r_q;

endmodule : sat_cnt
`default_nettype wire

// File: rtl/pipe_flush_ctrl.sv
`default_nettype none
// =============================================================================
// pipe_flush_ctrl : stall/flush arbiter with post-exception/ERET flush window.
// Optional macro PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
// Revision 1.0
// =============================================================================
module pipe_flush_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int COMMIT_STAGE = 3,
  parameter int CNT_W        = 32
) (
  input  wire logic        clk,
  input  wire logic        reset,
  pipe_flush_ctrl_if.slave bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
`endif
);

  localparam int NREG = NUM_STAGES - 1;
  localparam int CW   = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_pc_en;
  logic [1:0]      w_pc_sel;
  logic            w_epc_we;
  logic [NREG-1:0] w_reg_en;
  logic [NREG-1:0] w_reg_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_en     = 1'b1;
    w_pc_sel    = PCSEL_SEQ;
    w_epc_we    = 1'b0;
    w_reg_en    = '1;
    w_reg_clr   = '0;

    if (reset) begin
      w_pc_en   = 1'b0;
      w_reg_en  = '0;
      w_reg_clr = '1;
    end else if (bus.i_exc_req) begin
      // Kill the faulting instruction and everything younger; older ones drain
      for (int j = 0; j < NREG; j++) begin
        w_reg_clr[j] = (j <= int'(bus.i_exc_stage));
      end
      w_pc_sel = PCSEL_EXC;
      w_epc_we = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        w_state_nxt = ST_FLUSH;
        w_cnt_nxt   = CW'(FLUSH_CYCLES);
      end
    end else if (r_state == ST_FLUSH) begin
      w_pc_en           = 1'b0;
      w_reg_clr[STG_IF] = 1'b1;
      if (r_cnt <= CW'(1)) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
    end else if (bus.i_eret_req) begin
      for (int j = 0; j < NREG; j++) begin
        w_reg_clr[j] = (j <= COMMIT_STAGE);
      end
      w_pc_sel = PCSEL_EPC;
      if (FLUSH_CYCLES > 0) begin
        w_state_nxt = ST_FLUSH;
        w_cnt_nxt   = CW'(FLUSH_CYCLES);
      end
    end else if (bus.i_mdu_busy) begin
      w_pc_en           = 1'b0;
      w_reg_en[STG_IF]  = 1'b0;
      w_reg_en[STG_ID]  = 1'b0;
      w_reg_clr[STG_EX] = 1'b1;
    end else if (bus.i_ld_use_stall) begin
      w_pc_en           = 1'b0;
      w_reg_en[STG_IF]  = 1'b0;
      w_reg_clr[STG_ID] = 1'b1;
    end else if (bus.i_br_flush) begin
      w_reg_clr[STG_IF] = 1'b1;
    end
  end

  assign bus.o_pc_en   = w_pc_en;
  assign bus.o_pc_sel  = w_pc_sel;
  assign bus.o_epc_we  = w_epc_we;
  assign bus.o_reg_en  = w_reg_en;
  assign bus.o_reg_clr = w_reg_clr;
  assign bus.o_busy    = !reset && (r_state != ST_IDLE);

`ifdef PIPE_CTRL_PERF_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = !reset && !w_pc_en;
  assign w_flush_inc = !reset &&
                       (bus.i_exc_req || (bus.i_eret_req && (r_state == ST_IDLE)));

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_stall_inc),
    .o_q   (o_stall_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_flush_inc),
    .o_q   (o_flush_cnt)
  );
`endif

endmodule : pipe_flush_ctrl
`default_nettype wire

// File: tb/tb_pipe_flush_ctrl.sv
`default_nettype none
// =============================================================================
// tb_pipe_flush_ctrl : vector table, async-reset sequence and random vs model
// Revision 1.0
// =============================================================================
module tb_pipe_flush_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int NUM_STAGES   = 5;
  localparam int NREG         = NUM_STAGES - 1;
  localparam int FLUSH_CYCLES = 2;
  localparam int COMMIT_STAGE = 3;
  localparam int CNT_W        = 32;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       epc_we;
    logic [3:0] reg_en;
    logic [3:0] reg_clr;
    logic       busy;
  } out_t;

  typedef struct {
    logic       rst;
    logic       exc;
    logic [2:0] stg;
    logic       eret;
    logic       mdu;
    logic       ld;
    logic       br;
    out_t       exp;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_flush_ctrl_if #(.NUM_STAGES(NUM_STAGES)) bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  pipe_flush_ctrl #(
    .NUM_STAGES   (NUM_STAGES),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .COMMIT_STAGE (COMMIT_STAGE),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .o_stall_cnt (stall_cnt),
    .o_flush_cnt (flush_cnt)
`endif
  );

  function automatic out_t O(logic pe, logic [1:0] ps, logic ep,
                             logic [3:0] en, logic [3:0] clr, logic b);
    out_t o;
    o.pc_en = pe; o.pc_sel = ps; o.epc_we = ep;
    o.reg_en = en; o.reg_clr = clr; o.busy = b;
    return o;
  endfunction

  function automatic vec_t V(logic r, logic e, logic [2:0] s, logic er,
                             logic md, logic ld, logic br, out_t o);
    vec_t v;
    v.rst = r; v.exc = e; v.stg = s; v.eret = er;
    v.mdu = md; v.ld = ld; v.br = br; v.exp = o;
    return v;
  endfunction

  task automatic drive(input logic r, input logic e, input logic [2:0] s,
                       input logic er, input logic md, input logic ld, input logic br);
    reset              = r;
    bus.i_exc_req      = e;
    bus.i_exc_stage    = s;
    bus.i_eret_req     = er;
    bus.i_mdu_busy     = md;
    bus.i_ld_use_stall = ld;
    bus.i_br_flush     = br;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act.pc_en   = bus.o_pc_en;
    act.pc_sel  = bus.o_pc_sel;
    act.epc_we  = bus.o_epc_we;
    act.reg_en  = bus.o_reg_en;
    act.reg_clr = bus.o_reg_clr;
    act.busy    = bus.o_busy;
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got pc_en=%b pc_sel=%b epc_we=%b reg_en=%b reg_clr=%b busy=%b, expected pc_en=%b pc_sel=%b epc_we=%b reg_en=%b reg_clr=%b busy=%b",
               name, act.pc_en, act.pc_sel, act.epc_we, act.reg_en, act.reg_clr, act.busy,
               exp.pc_en, exp.pc_sel, exp.epc_we, exp.reg_en, exp.reg_clr, exp.busy);
    end
  endtask

  // Reference: 'left' is the number of bubble cycles still owed after an exception/ERET
  task automatic model(input logic r, input logic e, input logic [2:0] s, input logic er,
                       input logic md, input logic ld, input logic br, input int left,
                       output out_t o, output int nleft);
    int k;
    o = O(1'b1, PCSEL_SEQ, 1'b0, 4'b1111, 4'b0000, left > 0);
    nleft = (left > 0) ? left - 1 : 0;
    if (r) begin
      o = O(1'b0, PCSEL_SEQ, 1'b0, 4'b0000, 4'b1111, 1'b0);
      nleft = 0;
    end else if (e) begin
      k = (int'(s) > NREG - 1) ? NREG - 1 : int'(s);
      o.reg_clr = 4'((1 << (k + 1)) - 1);
      o.pc_sel  = PCSEL_EXC;
      o.epc_we  = 1'b1;
      nleft     = FLUSH_CYCLES;
    end else if (left > 0) begin
      o.pc_en   = 1'b0;
      o.reg_clr = 4'b0001;
    end else if (er) begin
      k = (COMMIT_STAGE > NREG - 1) ? NREG - 1 : COMMIT_STAGE;
      o.reg_clr = 4'((1 << (k + 1)) - 1);
      o.pc_sel  = PCSEL_EPC;
      nleft     = FLUSH_CYCLES;
    end else if (md) begin
      o.pc_en = 1'b0; o.reg_en = 4'b1100; o.reg_clr = 4'b0100;
    end else if (ld) begin
      o.pc_en = 1'b0; o.reg_en = 4'b1110; o.reg_clr = 4'b0010;
    end else if (br) begin
      o.reg_clr = 4'b0001;
    end
  endtask

  initial begin
    vec_t tbl[$];
    out_t D, F, R, exp;
    int   m_left, n_left;
`ifdef PIPE_CTRL_PERF_EN
    int   m_stall, m_flush;
`endif

    D = O(1'b1, PCSEL_SEQ, 1'b0, 4'b1111, 4'b0000, 1'b0);
    F = O(1'b0, PCSEL_SEQ, 1'b0, 4'b1111, 4'b0001, 1'b1);
    R = O(1'b0, PCSEL_SEQ, 1'b0, 4'b0000, 4'b1111, 1'b0);

    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, R));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, D));
    tbl.push_back(V(0, 1, 2, 0, 0, 0, 0, O(1, PCSEL_EXC, 1, 4'b1111, 4'b0111, 0)));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, F));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, F));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, D));
    tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, O(0, PCSEL_SEQ, 0, 4'b1110, 4'b0010, 0)));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 1, O(1, PCSEL_SEQ, 0, 4'b1111, 4'b0001, 0)));
    for (int i = 0; i < 4; i++)
      tbl.push_back(V(0, 0, 0, 0, 1, 0, 0, O(0, PCSEL_SEQ, 0, 4'b1100, 4'b0100, 0)));
    tbl.push_back(V(0, 1, 2, 0, 0, 0, 0, O(1, PCSEL_EXC, 1, 4'b1111, 4'b0111, 0)));
    tbl.push_back(V(0, 1, 1, 0, 0, 0, 0, O(1, PCSEL_EXC, 1, 4'b1111, 4'b0011, 1)));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, F));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, F));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, D));
    tbl.push_back(V(0, 1, 4, 1, 0, 0, 0, O(1, PCSEL_EXC, 1, 4'b1111, 4'b1111, 0)));
    tbl.push_back(V(0, 0, 0, 1, 0, 0, 0, F));
    tbl.push_back(V(0, 0, 0, 0, 1, 1, 1, F));
    tbl.push_back(V(0, 0, 0, 1, 0, 0, 0, O(1, PCSEL_EPC, 0, 4'b1111, 4'b1111, 0)));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, F));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, R));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, D));
    tbl.push_back(V(0, 0, 0, 0, 1, 1, 1, O(0, PCSEL_SEQ, 0, 4'b1100, 4'b0100, 0)));
    tbl.push_back(V(0, 1, 0, 0, 0, 0, 0, O(1, PCSEL_EXC, 1, 4'b1111, 4'b0001, 0)));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, F));
    tbl.push_back(V(0, 1, 7, 0, 0, 0, 0, O(1, PCSEL_EXC, 1, 4'b1111, 4'b1111, 1)));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, F));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, F));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, D));

    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    foreach (tbl[i]) begin
      #1;
      drive(tbl[i].rst, tbl[i].exc, tbl[i].stg, tbl[i].eret,
            tbl[i].mdu, tbl[i].ld, tbl[i].br);
      #3;
      check($sformatf("vec%0d", i), tbl[i].exp);
      @(posedge clk);
    end

    // Reset raised between edges while flushing must take effect immediately
    #1; drive(0, 1, 3, 0, 0, 0, 0);
    #3; check("async_exc", O(1, PCSEL_EXC, 1, 4'b1111, 4'b1111, 0));
    @(posedge clk);
    #1; drive(0, 0, 0, 0, 0, 0, 0);
    #3; check("async_pre", F);
    #1; reset = 1'b1;
    #1; check("async_rst", R);
    @(posedge clk);
    #1; reset = 1'b0;
    #3; check("async_rel", D);
    @(posedge clk);
    #4; check("async_rel2", D);

    m_left = 0;
`ifdef PIPE_CTRL_PERF_EN
    m_stall = 0;
    m_flush = 0;
`endif
    for (int c = 0; c < 400; c++) begin
      logic r, e, er, md, ld, br;
      logic [2:0] s;
      @(posedge clk);
      #1;
      r  = (c == 0) || ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 11) == 0);
      s  = 3'($urandom_range(0, 7));
      er = ($urandom_range(0, 7) == 0);
      md = ($urandom_range(0, 4) == 0);
      ld = ($urandom_range(0, 4) == 0);
      br = ($urandom_range(0, 3) == 0);
      drive(r, e, s, er, md, ld, br);
      model(r, e, s, er, md, ld, br, m_left, exp, n_left);
      #3;
      check($sformatf("rand%0d", c), exp);
`ifdef PIPE_CTRL_PERF_EN
      if (r) begin
        m_stall = 0;
        m_flush = 0;
      end
      checks++;
      if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
        failures++;
        $display("FAIL perf%0d: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                 c, stall_cnt, flush_cnt, m_stall, m_flush);
      end
      if (!r && !exp.pc_en) m_stall++;
      if (!r && (exp.pc_sel != PCSEL_SEQ)) m_flush++;
`endif
      m_left = n_left;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_flush_ctrl
`default_nettype wire
